// File: rtl/isla_delay_cal_ctrl.sv
// rtl/isla_delay_cal_ctrl.sv - ISLA lane IDELAY tap sweep/centring sequencer with manual load arbitration
module isla_delay_cal_ctrl #(
  parameter int G_SETTLE_CYCLES = 16,
  parameter int G_SAMPLE_CYCLES = 256,
  parameter int G_MIN_WINDOW    = 4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        cal_start_i,
  input  logic        man_req_i,
  input  logic [7:0]  man_lane_sel_i,
  input  logic [4:0]  man_tap_i,
  input  logic [7:0]  pattern_ok_i,
  input  logic        delay_rdy_i,
  output logic [4:0]  delay_reg_o,
  output logic [7:0]  delay_select_o,
  output logic        delay_load_o,
  output logic        man_ack_o,
  output logic        cal_busy_o,
  output logic        cal_done_o,
  output logic        cal_fail_o,
  output logic [7:0]  lane_fail_o,
  output logic [39:0] lane_tap_o
);

  // One counter serves the load sub-cycles, settle, sample and the 32-step scan.
  localparam int MAX_A = (G_SAMPLE_CYCLES > G_SETTLE_CYCLES) ? G_SAMPLE_CYCLES : G_SETTLE_CYCLES;
  localparam int MAX_C = (MAX_A > 32) ? MAX_A : 32;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] C_LAST_LD  = CW'(4);
  localparam logic [CW-1:0] C_LAST_SET = CW'(G_SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST_SMP = CW'(G_SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST_EVL = CW'(31);
  localparam logic [5:0]    MIN_LEN    = 6'(G_MIN_WINDOW);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SETTLE, S_SAMPLE,
    S_NEXT, S_EVAL, S_FINAL_LOAD, S_DONE, S_MAN_LOAD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    lane_q, lane_d;
  logic [4:0]    tap_q, tap_d;
  logic          ok_q, ok_d;
  logic [31:0]   pass_map_q, pass_map_d;
  logic [4:0]    cur_start_q, cur_start_d;
  logic [5:0]    cur_len_q, cur_len_d;
  logic [4:0]    best_start_q, best_start_d;
  logic [5:0]    best_len_q, best_len_d;
  logic [4:0]    reg_q, reg_d;
  logic [7:0]    sel_q, sel_d;
  logic          load_q, load_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic [7:0]    lane_fail_q, lane_fail_d;
  logic [39:0]   lane_tap_q, lane_tap_d;

  logic          scan_bit;
  logic [5:0]    run_len, win_len;
  logic [4:0]    run_start, win_start, win_tap;
  logic          ok_now;
  logic [7:0]    lane_onehot, next_onehot;

  assign delay_reg_o    = reg_q;
  assign delay_select_o = sel_q;
  assign delay_load_o   = load_q;
  assign man_ack_o      = ack_q;
  assign cal_busy_o     = busy_q;
  assign cal_done_o     = done_q;
  assign cal_fail_o     = fail_q;
  assign lane_fail_o    = lane_fail_q;
  assign lane_tap_o     = lane_tap_q;

  // State and all registered outputs; reset drops the load strobe immediately.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      tap_q        <= '0;
      ok_q         <= 1'b0;
      pass_map_q   <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      reg_q        <= '0;
      sel_q        <= '0;
      load_q       <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      lane_fail_q  <= '0;
      lane_tap_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      ok_q         <= ok_d;
      pass_map_q   <= pass_map_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      reg_q        <= reg_d;
      sel_q        <= sel_d;
      load_q       <= load_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      lane_fail_q  <= lane_fail_d;
      lane_tap_q   <= lane_tap_d;
    end
  end

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    ok_d         = ok_q;
    pass_map_d   = pass_map_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    reg_d        = reg_q;
    sel_d        = sel_q;
    ack_d        = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
    lane_fail_d  = lane_fail_q;
    lane_tap_d   = lane_tap_q;

    lane_onehot = 8'b1 << lane_q;
    next_onehot = 8'b1 << (lane_q + 3'd1);
    ok_now      = ok_q & pattern_ok_i[lane_q];

    // Streaming longest-run scan: strict '>' keeps the earliest run on ties.
    scan_bit  = pass_map_q[cnt_q[4:0]];
    run_len   = scan_bit ? (cur_len_q + 6'd1) : 6'd0;
    run_start = (scan_bit && (cur_len_q == 6'd0)) ? cnt_q[4:0] : cur_start_q;
    if (run_len > best_len_q) begin
      win_len   = run_len;
      win_start = run_start;
    end else begin
      win_len   = best_len_q;
      win_start = best_start_q;
    end
    win_tap = (win_len >= MIN_LEN) ? (win_start + 5'((win_len - 6'd1) >> 1)) : 5'd0;

    case (state_q)
      S_IDLE: begin
        // While the ack pulse is out the host still holds man_req_i; don't re-accept it.
        if (man_req_i && !ack_q) begin
          state_d = S_MAN_LOAD;
          cnt_d   = '0;
          sel_d   = man_lane_sel_i;
          reg_d   = man_tap_i;
        end else if (cal_start_i) begin
          state_d     = S_WAIT_RDY;
          busy_d      = 1'b1;
          lane_d      = '0;
          lane_fail_d = '0;
          fail_d      = 1'b0;
          lane_tap_d  = '0;
        end
      end
      S_WAIT_RDY: begin
        if (delay_rdy_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          tap_d   = '0;
          reg_d   = '0;
          sel_d   = lane_onehot;
        end
      end
      S_LOAD: begin
        if (cnt_q == C_LAST_LD) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          sel_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == C_LAST_SET) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
          ok_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SAMPLE: begin
        ok_d = ok_now;
        if (cnt_q == C_LAST_SMP) begin
          pass_map_d[tap_q] = ok_now;
          state_d           = S_NEXT;
          cnt_d             = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (tap_q != 5'd31) begin
          state_d = S_LOAD;
          tap_d   = tap_q + 5'd1;
          reg_d   = tap_q + 5'd1;
          sel_d   = lane_onehot;
        end else begin
          state_d      = S_EVAL;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
        end
      end
      S_EVAL: begin
        cur_len_d    = run_len;
        cur_start_d  = run_start;
        best_len_d   = win_len;
        best_start_d = win_start;
        if (cnt_q == C_LAST_EVL) begin
          lane_tap_d[int'(lane_q)*5 +: 5] = win_tap;
          lane_fail_d[lane_q]             = (win_len < MIN_LEN);
          state_d = S_FINAL_LOAD;
          cnt_d   = '0;
          reg_d   = win_tap;
          sel_d   = lane_onehot;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINAL_LOAD: begin
        if (cnt_q == C_LAST_LD) begin
          cnt_d = '0;
          if (lane_q != 3'd7) begin
            state_d = S_LOAD;
            lane_d  = lane_q + 3'd1;
            tap_d   = '0;
            reg_d   = '0;
            sel_d   = next_onehot;
          end else begin
            state_d = S_DONE;
            sel_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            fail_d  = |lane_fail_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_MAN_LOAD: begin
        if (cnt_q == C_LAST_LD) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sel_d   = '0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sel_d   = '0;
      end
    endcase

    // Strobe is high on sub-cycles 1..2 of any load sequence that selects at least one lane.
    load_d = ((state_d == S_LOAD) || (state_d == S_FINAL_LOAD) || (state_d == S_MAN_LOAD)) &&
             ((cnt_d == CW'(1)) || (cnt_d == CW'(2))) && (sel_d != 8'd0);
  end

endmodule

// File: tb/tb_isla_delay_cal_ctrl.sv
// tb/tb_isla_delay_cal_ctrl.sv - self-checking bench for isla_delay_cal_ctrl
module tb_isla_delay_cal_ctrl;

  localparam int SET       = 2;
  localparam int SMP       = 4;
  localparam int MINW      = 4;
  localparam int T_TAP     = 5 + SET + SMP + 1;
  localparam int LANE_CYC  = 32 * T_TAP + 32 + 5;
  localparam int DONE_LAT  = 1 + 8 * LANE_CYC + 1;
  localparam int CAL_LIMIT = DONE_LAT + 400;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cal_start = 1'b0;
  logic        man_req = 1'b0;
  logic [7:0]  man_lane_sel = '0;
  logic [4:0]  man_tap = '0;
  logic [7:0]  pattern_ok;
  logic        delay_rdy = 1'b1;
  logic [4:0]  delay_reg;
  logic [7:0]  delay_select;
  logic        delay_load;
  logic        man_ack;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;
  logic [7:0]  lane_fail;
  logic [39:0] lane_tap;

  int checks = 0;
  int errors = 0;

  logic [7:0][31:0] mask_cur = '0;
  logic [4:0]       cur_tap [8] = '{default: 5'd0};
  int               n_strobe = 0;
  int               n_man_strobe = 0;
  logic [4:0]       last_l3_reg = '0;

  typedef struct {
    logic [7:0][31:0] mask;
    logic [39:0]      exp_tap;
    logic [7:0]       exp_fail;
  } vec_t;

  vec_t vecs [4];

  isla_delay_cal_ctrl #(
    .G_SETTLE_CYCLES(SET),
    .G_SAMPLE_CYCLES(SMP),
    .G_MIN_WINDOW   (MINW)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .cal_start_i   (cal_start),
    .man_req_i     (man_req),
    .man_lane_sel_i(man_lane_sel),
    .man_tap_i     (man_tap),
    .pattern_ok_i  (pattern_ok),
    .delay_rdy_i   (delay_rdy),
    .delay_reg_o   (delay_reg),
    .delay_select_o(delay_select),
    .delay_load_o  (delay_load),
    .man_ack_o     (man_ack),
    .cal_busy_o    (cal_busy),
    .cal_done_o    (cal_done),
    .cal_fail_o    (cal_fail),
    .lane_fail_o   (lane_fail),
    .lane_tap_o    (lane_tap)
  );

  always #5 sys_clk = ~sys_clk;

  // Interface-block model: each selected lane takes the tap on the strobe's rising edge.
  always @(posedge delay_load) begin
    n_strobe <= n_strobe + 1;
    for (int l = 0; l < 8; l++)
      if (delay_select[l]) cur_tap[l] <= delay_reg;
    if (delay_select == 8'h81) n_man_strobe <= n_man_strobe + 1;
    if (delay_select == 8'h08) last_l3_reg <= delay_reg;
  end

  // ADC test pattern: a lane matches when its current tap is inside its passing mask.
  always_comb begin
    pattern_ok = '0;
    for (int l = 0; l < 8; l++) pattern_ok[l] = mask_cur[l][cur_tap[l]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: enumerate every maximal run by its start, keep the first longest.
  function automatic void ref_model(input logic [7:0][31:0] m, output logic [39:0] tap,
                                    output logic [7:0] fail);
    tap  = '0;
    fail = '0;
    for (int l = 0; l < 8; l++) begin
      int bs = 0;
      int bl = 0;
      for (int s = 0; s < 32; s++) begin
        if (m[l][s] && ((s == 0) ? 1'b1 : !m[l][s-1])) begin
          int len = 0;
          while ((s + len < 32) && m[l][s+len]) len++;
          if (len > bl) begin
            bl = len;
            bs = s;
          end
        end
      end
      if (bl < MINW) fail[l] = 1'b1;
      else tap[l*5 +: 5] = 5'(bs + (bl - 1) / 2);
    end
  endfunction

  function automatic logic [39:0] iface_taps();
    logic [39:0] v;
    for (int l = 0; l < 8; l++) v[l*5 +: 5] = cur_tap[l];
    return v;
  endfunction

  task automatic run_cal(input string tag, input logic [7:0][31:0] m, input logic [39:0] exp_tap,
                         input logic [7:0] exp_fail, input int man_at, input int rdy_hold,
                         input bit check_lat);
    int cyc;
    int s0;
    int ms0;
    int acks;
    int hi;
    mask_cur = m;
    @(negedge sys_clk);
    delay_rdy = (rdy_hold == 0);
    cal_start = 1'b1;
    s0  = n_strobe;
    ms0 = n_man_strobe;
    @(negedge sys_clk);
    cal_start = 1'b0;
    cyc = 1;
    while (!cal_done && cyc < CAL_LIMIT) begin
      if (man_at != 0 && cyc == man_at) begin
        man_req      = 1'b1;
        man_lane_sel = 8'h81;
        man_tap      = 5'd9;
      end
      if (rdy_hold != 0 && cyc == rdy_hold) begin
        chk({tag, " strobes while not ready"}, 64'(n_strobe - s0), 64'd0);
        chk({tag, " busy while not ready"}, 64'(cal_busy), 64'd1);
        delay_rdy = 1'b1;
      end
      @(negedge sys_clk);
      cyc++;
    end
    chk({tag, " done seen"}, 64'(cal_done), 64'd1);
    if (check_lat) chk({tag, " done latency"}, 64'(cyc), 64'(DONE_LAT));
    chk({tag, " lane_tap"}, 64'(lane_tap), 64'(exp_tap));
    chk({tag, " lane_fail"}, 64'(lane_fail), 64'(exp_fail));
    chk({tag, " cal_fail"}, 64'(cal_fail), 64'(|exp_fail));
    chk({tag, " loaded taps"}, 64'(iface_taps()), 64'(exp_tap));
    if (man_at != 0) begin
      chk({tag, " manual strobes before done"}, 64'(n_man_strobe - ms0), 64'd0);
      acks = 0;
      hi   = 0;
      for (int c = 0; c < 25; c++) begin
        @(negedge sys_clk);
        if (delay_load) hi++;
        if (man_ack) begin
          acks++;
          man_req = 1'b0;
        end
      end
      chk({tag, " manual acks"}, 64'(acks), 64'd1);
      chk({tag, " manual strobes"}, 64'(n_man_strobe - ms0), 64'd1);
      chk({tag, " manual strobe width"}, 64'(hi), 64'd2);
    end else begin
      @(negedge sys_clk);
      chk({tag, " done is one pulse"}, 64'(cal_done), 64'd0);
      chk({tag, " busy after done"}, 64'(cal_busy), 64'd0);
    end
  endtask

  task automatic man_seq(input string tag, input logic [7:0] sel, input logic [4:0] tap,
                         input bit with_start);
    logic [11:0] ld_bits;
    logic [11:0] ack_bits;
    logic        busy_seen;
    logic [12:0] held;
    ld_bits   = '0;
    ack_bits  = '0;
    busy_seen = 1'b0;
    held      = '0;
    @(negedge sys_clk);
    man_req      = 1'b1;
    man_lane_sel = sel;
    man_tap      = tap;
    cal_start    = with_start;
    for (int c = 1; c < 12; c++) begin
      @(negedge sys_clk);
      cal_start   = 1'b0;
      ld_bits[c]  = delay_load;
      ack_bits[c] = man_ack;
      busy_seen   = busy_seen | cal_busy | cal_done;
      if (c == 2) held = {delay_reg, delay_select};
      if (man_ack) man_req = 1'b0;
    end
    chk({tag, " strobe cycles"}, 64'(ld_bits), (sel != 8'd0) ? 64'h00C : 64'h000);
    chk({tag, " ack cycles"}, 64'(ack_bits), 64'h040);
    chk({tag, " no calibration"}, 64'(busy_seen), 64'd0);
    chk({tag, " reg/select held"}, 64'(held), 64'({tap, sel}));
    chk({tag, " select released"}, 64'(delay_select), 64'd0);
  endtask

  initial begin
    logic [7:0][31:0] rm;
    logic [39:0]      rtap;
    logic [7:0]       rfail;
    int               cyc;

    vecs[0].mask     = {8{32'hFFFF_FFFF}};
    vecs[0].exp_tap  = {8{5'd15}};
    vecs[0].exp_fail = 8'h00;
    vecs[1].mask     = {8{32'hFFFF_FFFF}};
    vecs[1].mask[3]  = 32'h0003_FC00;
    vecs[1].exp_tap  = {5'd15, 5'd15, 5'd15, 5'd15, 5'd13, 5'd15, 5'd15, 5'd15};
    vecs[1].exp_fail = 8'h00;
    vecs[2].mask     = {8{32'hFFFF_FFFF}};
    vecs[2].mask[0]  = 32'h00F0_003C;
    vecs[2].mask[5]  = 32'h0000_0000;
    vecs[2].exp_tap  = {5'd15, 5'd15, 5'd0, 5'd15, 5'd15, 5'd15, 5'd15, 5'd3};
    vecs[2].exp_fail = 8'h20;
    vecs[3].mask     = {32'hF800_0000, 32'hFFFE_FFFF, 32'h0000_000F, 32'h5555_5555,
                        32'hFFFF_FFFF, 32'hF000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[3].exp_tap  = {5'd29, 5'd7, 5'd1, 5'd0, 5'd15, 5'd29, 5'd0, 5'd15};
    vecs[3].exp_fail = 8'h12;

    // Reset state.
    repeat (3) @(negedge sys_clk);
    chk("reset ctrl outputs", 64'({delay_reg, delay_select, delay_load, man_ack, cal_busy,
                                    cal_done, cal_fail, lane_fail}), 64'd0);
    chk("reset lane_tap", 64'(lane_tap), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Directed windows.
    for (int i = 0; i < 4; i++) begin
      run_cal($sformatf("vec%0d", i), vecs[i].mask, vecs[i].exp_tap, vecs[i].exp_fail, 0, 0, 1'b1);
      if (i == 1) chk("lane3 final load tap", 64'(last_l3_reg), 64'd13);
    end

    // Manual request raised mid-calibration waits for DONE.
    run_cal("cal+man", vecs[0].mask, vecs[0].exp_tap, vecs[0].exp_fail, 300, 0, 1'b1);

    // IDLE arbitration: manual wins, start dropped; empty select is acked without a strobe.
    man_seq("man+start", 8'h81, 5'd21, 1'b1);
    man_seq("man sel0", 8'h00, 5'd6, 1'b0);

    // IDELAYCTRL not ready for 100 cycles.
    run_cal("rdy hold", vecs[2].mask, vecs[2].exp_tap, vecs[2].exp_fail, 0, 100, 1'b0);

    // Asynchronous reset while the strobe is high mid-sweep.
    mask_cur = vecs[0].mask;
    @(negedge sys_clk);
    cal_start = 1'b1;
    @(negedge sys_clk);
    cal_start = 1'b0;
    cyc = 1;
    while (!(cyc > 800 && delay_load) && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("strobe found mid-sweep", 64'(delay_load), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset ctrl outputs", 64'({delay_reg, delay_select, delay_load, man_ack, cal_busy,
                                          cal_done, cal_fail, lane_fail}), 64'd0);
    chk("async reset lane_tap", 64'(lane_tap), 64'd0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge sys_clk);
        seen = seen | cal_done | cal_busy;
      end
      chk("no done after abort", 64'(seen), 64'd0);
    end
    run_cal("after reset", vecs[1].mask, vecs[1].exp_tap, vecs[1].exp_fail, 0, 0, 1'b1);

    // Randomized lane masks against the reference model.
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < 8; l++) begin
        logic [31:0] m;
        int s;
        int len;
        m = '0;
        case ($urandom_range(0, 3))
          0: m = $urandom;
          1: begin
            s   = $urandom_range(0, 31);
            len = $urandom_range(1, 32 - s);
            for (int t = s; t < s + len; t++) m[t] = 1'b1;
          end
          2: begin
            for (int w = 0; w < 2; w++) begin
              s   = $urandom_range(0, 31);
              len = $urandom_range(1, 8);
              for (int t = s; t < s + len && t < 32; t++) m[t] = 1'b1;
            end
          end
          default: m = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
        endcase
        rm[l] = m;
      end
      ref_model(rm, rtap, rfail);
      run_cal($sformatf("rand%0d", r), rm, rtap, rfail, 0, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
